// File: rtl/i2c_slave_responder_if.sv
// Serial address/read link bundle between a bus master and one responder.
// The master drives SCLK/RX plus the responder's static ADDR/DATA; the responder drives the status and OUT.
interface i2c_slave_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              SCLK;
    logic              RX;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA;
    logic              OUT;
    logic              BUSY;
    logic              MATCH;
    logic              DONE;

    modport master (
        output SCLK, RX, ADDR, DATA,
        input  OUT, BUSY, MATCH, DONE
    );

    modport slave (
        input  SCLK, RX, ADDR, DATA,
        output OUT, BUSY, MATCH, DONE
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// Clock-synchronous responder: receives an address on RX/SCLK, acks a match and
// returns DATA MSB-first on a wired-OR OUT line, with burst reads on master ack.
module i2c_slave_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8
) (
    input logic                  CLK,
    input logic                  RSTN,
    i2c_slave_responder_if.slave bus
);
    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK,
        S_TX,
        S_MACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic                   r_sclk_d;
    logic                   r_rx_d;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W-1:0] r_addr_sr;
    logic [DATA_W-1:0] r_tx_sr;
    logic              r_out;
    logic              r_busy;
    logic              r_match;
    logic              r_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_tx_nxt;
    logic              w_out_nxt;
    logic              w_busy_nxt;
    logic              w_match_nxt;
    logic              w_done_nxt;

    logic              w_sclk;
    logic              w_rx;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_start;
    logic              w_stop;
    logic [ADDR_W-1:0] w_addr_shift;

    // Synchronisers plus one history flop; idle-high bus level out of reset
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sclk_sync <= '1;
            r_rx_sync   <= '1;
            r_sclk_d    <= 1'b1;
            r_rx_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            r_rx_sync   <= {r_rx_sync[SYNC_STAGES-2:0], bus.RX};
            r_sclk_d    <= w_sclk;
            r_rx_d      <= w_rx;
        end
    end

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_rx         = r_rx_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk & ~r_sclk_d;
    assign w_sclk_fall  = ~w_sclk & r_sclk_d;
    // RX edges only count as START/STOP when SCLK is high on both sides of the edge
    assign w_start      = w_sclk & r_sclk_d & r_rx_d & ~w_rx;
    assign w_stop       = w_sclk & r_sclk_d & ~r_rx_d & w_rx;
    assign w_addr_shift = {r_addr_sr[ADDR_W-2:0], w_rx};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_addr_sr <= '0;
            r_tx_sr   <= '0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_addr_sr <= w_addr_nxt;
            r_tx_sr   <= w_tx_nxt;
            r_out     <= w_out_nxt;
            r_busy    <= w_busy_nxt;
            r_match   <= w_match_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_addr_nxt  = r_addr_sr;
        w_tx_nxt    = r_tx_sr;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_match_nxt = r_match;
        w_done_nxt  = 1'b0;

        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_match_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
            w_match_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_sclk_rise) begin
                        w_addr_nxt = w_addr_shift;
                        if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            w_cnt_nxt = '0;
                            if (w_addr_shift == bus.ADDR) begin
                                w_state_nxt = S_ACK;
                                w_match_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end else begin
                            w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                // Counter 0: ack bit not yet driven; 1: ack on the bus, next fall loads data
                S_ACK: begin
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_out_nxt = 1'b1;
                            w_cnt_nxt = CNT_W'(1);
                        end else begin
                            w_tx_nxt    = bus.DATA;
                            w_out_nxt   = bus.DATA[DATA_W-1];
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_TX;
                        end
                    end
                end
                S_TX: begin
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            w_out_nxt   = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_MACK;
                        end else begin
                            w_tx_nxt  = {r_tx_sr[DATA_W-2:0], 1'b0};
                            w_out_nxt = r_tx_sr[DATA_W-2];
                            w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                // Counter 0: waiting for the master's ack bit; 1: acked, reload on next fall
                S_MACK: begin
                    w_out_nxt = 1'b0;
                    if ((r_bit_cnt == '0) && w_sclk_rise) begin
                        if (!w_rx) begin
                            w_cnt_nxt = CNT_W'(1);
                        end else begin
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end else if ((r_bit_cnt != '0) && w_sclk_fall) begin
                        w_tx_nxt    = bus.DATA;
                        w_out_nxt   = bus.DATA[DATA_W-1];
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_TX;
                    end
                end
                S_WAIT_STOP: begin
                    w_out_nxt = 1'b0;
                end
                default: begin
                    w_out_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.OUT   = r_out;
    assign bus.BUSY  = r_busy;
    assign bus.MATCH = r_match;
    assign bus.DONE  = r_done;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Four responders on one wired-OR bus driven by a behavioural master; returned
// bytes are checked by a DONE-triggered scoreboard against pushed expectations.
module tb_i2c_slave_responder;
    localparam time T_CLK = 10ns;
    localparam time T_Q   = 50ns;

    logic       clk;
    logic       rst_n;
    logic       r_sclk;
    logic       r_rx;
    logic [7:0] r_addr [4];
    logic [7:0] r_data [4];

    int n_checks;
    int n_fail;
    int n_out_hi;

    logic [7:0] exp_q [$];
    logic [7:0] r_hist;

    i2c_slave_responder_if bus0 ();
    i2c_slave_responder_if bus1 ();
    i2c_slave_responder_if bus2 ();
    i2c_slave_responder_if bus3 ();

    assign bus0.SCLK = r_sclk; assign bus0.RX = r_rx; assign bus0.ADDR = r_addr[0]; assign bus0.DATA = r_data[0];
    assign bus1.SCLK = r_sclk; assign bus1.RX = r_rx; assign bus1.ADDR = r_addr[1]; assign bus1.DATA = r_data[1];
    assign bus2.SCLK = r_sclk; assign bus2.RX = r_rx; assign bus2.ADDR = r_addr[2]; assign bus2.DATA = r_data[2];
    assign bus3.SCLK = r_sclk; assign bus3.RX = r_rx; assign bus3.ADDR = r_addr[3]; assign bus3.DATA = r_data[3];

    i2c_slave_responder u0 (.CLK(clk), .RSTN(rst_n), .bus(bus0.slave));
    i2c_slave_responder u1 (.CLK(clk), .RSTN(rst_n), .bus(bus1.slave));
    i2c_slave_responder u2 (.CLK(clk), .RSTN(rst_n), .bus(bus2.slave));
    i2c_slave_responder u3 (.CLK(clk), .RSTN(rst_n), .bus(bus3.slave));

    logic w_in_data;
    logic w_done_any;
    assign w_in_data  = bus0.OUT | bus1.OUT | bus2.OUT | bus3.OUT;
    assign w_done_any = bus0.DONE | bus1.DONE | bus2.DONE | bus3.DONE;

    initial clk = 1'b0;
    always #(T_CLK / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Master samples IN_DATA mid-high; keep the last 8 samples for the scoreboard
    always @(posedge r_sclk) begin
        #(T_Q);
        r_hist = {r_hist[6:0], w_in_data};
    end

    always @(negedge clk) begin
        if (w_in_data) n_out_hi++;
    end

    // Scoreboard monitor: every DONE pulse retires one expected byte
    always @(negedge clk) begin
        if (w_done_any) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(r_hist), 32'hFFFF_FFFF);
            end else begin
                check("rx_byte", 32'(r_hist), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic sbit(input logic b, output logic s);
        r_rx = b;
        #(T_Q);
        r_sclk = 1'b1;
        #(T_Q);
        s = w_in_data;
        #(T_Q);
        r_sclk = 1'b0;
        #(T_Q);
    endtask

    task automatic start_c();
        if (!r_sclk) begin
            r_rx = 1'b1;
            #(T_Q);
            r_sclk = 1'b1;
            #(T_Q);
        end
        r_rx = 1'b0;
        #(T_Q);
        r_sclk = 1'b0;
        #(T_Q);
    endtask

    task automatic stop_c();
        r_rx = 1'b0;
        #(T_Q);
        r_sclk = 1'b1;
        #(T_Q);
        r_rx = 1'b1;
        #(2 * T_Q);
    endtask

    task automatic send_addr(input logic [7:0] a);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(a[i], s);
    endtask

    task automatic read_bits(input int n);
        logic s;
        for (int i = 0; i < n; i++) sbit(1'b1, s);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        int   hi0;
        n_checks = 0;
        n_fail   = 0;
        n_out_hi = 0;
        r_hist   = '0;
        r_sclk   = 1'b1;
        r_rx     = 1'b1;
        r_addr[0] = 8'h1A; r_data[0] = 8'h5D;
        r_addr[1] = 8'h1B; r_data[1] = 8'h3F;
        r_addr[2] = 8'h2A; r_data[2] = 8'h41;
        r_addr[3] = 8'h2B; r_data[3] = 8'h6C;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out",   32'(bus0.OUT),   32'd0);
        check("reset_busy",  32'(bus0.BUSY),  32'd0);
        check("reset_match", 32'(bus0.MATCH), 32'd0);
        check("reset_done",  32'(bus0.DONE),  32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single read of 0x1A returning 0x5D, then nack
        start_c();
        check("busy_after_start", 32'(bus0.BUSY), 32'd1);
        send_addr(8'h1A);
        exp_q.push_back(8'h5D);
        sbit(1'b1, s);
        check("ack_1a", 32'(s), 32'd1);
        check("match_1a", 32'(bus0.MATCH), 32'd1);
        read_bits(8);
        sbit(1'b1, s);
        check("busy_before_stop", 32'(bus0.BUSY), 32'd1);
        stop_c();
        check("busy_after_stop",  32'(bus0.BUSY),  32'd0);
        check("match_after_stop", 32'(bus0.MATCH), 32'd0);
        check("out_after_stop",   32'(w_in_data),  32'd0);

        // Non-matching address: nobody on the bus owns 0x1B for this frame
        r_addr[1] = 8'h7F;
        hi0 = n_out_hi;
        start_c();
        send_addr(8'h1B);
        sbit(1'b1, s);
        check("nack_1b", 32'(s), 32'd0);
        read_bits(8);
        sbit(1'b1, s);
        check("nomatch_match", 32'(bus0.MATCH), 32'd0);
        check("nomatch_busy",  32'(bus0.BUSY),  32'd1);
        stop_c();
        check("nomatch_out_silent", 32'(n_out_hi - hi0), 32'd0);
        check("nomatch_busy_stop",  32'(bus0.BUSY),      32'd0);
        r_addr[1] = 8'h1B;
        repeat (4) @(posedge clk);

        // Four responders read in turn over the shared bus
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a;
            logic [7:0] d;
            case (k)
                0: begin a = 8'h1A; d = 8'h5D; end
                1: begin a = 8'h1B; d = 8'h3F; end
                2: begin a = 8'h2A; d = 8'h41; end
                default: begin a = 8'h2B; d = 8'h6C; end
            endcase
            start_c();
            send_addr(a);
            exp_q.push_back(d);
            sbit(1'b1, s);
            check("multi_ack", 32'(s), 32'd1);
            check("multi_one_match",
                  32'($countones({bus0.MATCH, bus1.MATCH, bus2.MATCH, bus3.MATCH})), 32'd1);
            read_bits(8);
            sbit(1'b1, s);
            stop_c();
            check("multi_busy_idle", 32'({bus0.BUSY, bus1.BUSY, bus2.BUSY, bus3.BUSY}), 32'd0);
        end

        // Burst read from 0x2A; DATA changes mid-byte and only shows in byte 2
        start_c();
        send_addr(8'h2A);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        sbit(1'b1, s);
        check("burst_ack", 32'(s), 32'd1);
        read_bits(3);
        r_data[2] = 8'h42;
        read_bits(5);
        sbit(1'b0, s);
        read_bits(8);
        sbit(1'b1, s);
        stop_c();

        // Repeated START after 3 data bits, then a clean full read
        start_c();
        send_addr(8'h2B);
        sbit(1'b1, s);
        check("rs_first_ack", 32'(s), 32'd1);
        read_bits(3);
        start_c();
        check("rs_match_cleared", 32'(bus3.MATCH), 32'd0);
        send_addr(8'h2B);
        exp_q.push_back(8'h6C);
        sbit(1'b1, s);
        check("rs_second_ack", 32'(s), 32'd1);
        read_bits(8);
        sbit(1'b1, s);
        stop_c();

        // Reset mid-TX: 0x6C bit 2 (a 1) is on OUT when reset hits
        start_c();
        send_addr(8'h2B);
        sbit(1'b1, s);
        read_bits(2);
        check("pre_reset_out", 32'(bus3.OUT), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out",   32'(bus3.OUT),   32'd0);
        check("rst_busy",  32'(bus3.BUSY),  32'd0);
        check("rst_match", 32'(bus3.MATCH), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hi0 = n_out_hi;
        read_bits(6);
        check("post_reset_silent", 32'(n_out_hi - hi0), 32'd0);
        check("post_reset_busy",   32'(bus3.BUSY),      32'd0);
        stop_c();
        start_c();
        send_addr(8'h2B);
        exp_q.push_back(8'h6C);
        sbit(1'b1, s);
        check("post_reset_ack", 32'(s), 32'd1);
        read_bits(8);
        sbit(1'b1, s);
        stop_c();

        repeat (10) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
